// File: rtl/sobel_stream_norm.sv
// rtl/sobel_stream_norm.sv - streaming 3x3 Sobel edge detector with frame-to-frame peak normalisation
module sobel_stream_norm #(
  parameter int DATA_W   = 8,
  parameter int IMG_W    = 247,
  parameter int IMG_H    = 242,
  parameter int MAG_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sof,
  output logic              out_eol,
  output logic [DATA_W+2:0] frame_max
);
  localparam int MAG_W = DATA_W + 3;
  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H + 2);
  localparam int PW    = $clog2(MAG_W);
  localparam int WW    = MAG_W + DATA_W;

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_FL    = RW'(IMG_H);
  localparam logic [RW-1:0] ROW_FLEND = RW'(IMG_H + 1);
  localparam logic [PW-1:0] P_UNITY   = PW'(DATA_W - 1);

  typedef enum logic {RUN, FLUSH} state_t;
  state_t state_q, state_d;

  logic              active_q;
  logic [CW-1:0]     pos_col, c_col;
  logic [RW-1:0]     pos_row, c_row;
  logic              step, adv, frame_done, produce, c_border;
  logic [DATA_W-1:0] pix_in, lb1_rd, lb2_rd;
  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] lb2 [IMG_W];
  logic [DATA_W-1:0] win [3][3];
  logic [MAG_W-1:0]  gx_pos, gx_neg, gy_pos, gy_neg, ax_c, ay_c;
  logic              w_valid, w_sof, w_eol, w_border;
  logic              s1_valid, s1_sof, s1_eol, s1_border;
  logic [MAG_W-1:0]  s1_ax, s1_ay, mag_c, mag_hi, mag_lo, run_max;
  logic [PW-1:0]     p_q, p_next;
  logic [WW-1:0]     scaled;
  logic [DATA_W-1:0] norm_c;

  // The whole pipeline moves as one unit whenever the output register can be vacated
  assign step   = !out_valid || out_ready;
  assign pix_in = (state_q == FLUSH) ? '0 : in_data;
  assign lb1_rd = lb1[pos_col];
  assign lb2_rd = lb2[pos_col];

  // Next state, handshake and advance strobe
  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    adv        = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      RUN: begin
        in_ready = active_q && step;
        adv      = in_ready && in_valid;
        if (adv && pos_row == ROW_LAST && pos_col == COL_LAST) state_d = FLUSH;
      end
      FLUSH: begin
        adv = step;
        if (step && pos_row == ROW_FLEND && pos_col == '0) begin
          state_d    = RUN;
          frame_done = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Centre coordinate of the window after this advance: one row and one column behind the input
  always_comb begin
    produce = (pos_row > RW'(1)) || (pos_row == RW'(1) && pos_col != '0);
    c_row   = pos_row - RW'(1);
    c_col   = pos_col - CW'(1);
    if (pos_col == '0) begin
      c_row = pos_row - RW'(2);
      c_col = COL_LAST;
    end
    c_border = (c_row == '0) || (c_row == ROW_LAST) || (c_col == '0) || (c_col == COL_LAST);
  end

  // Line buffers and the 3x3 window carry no reset; stale contents only reach border outputs
  always_ff @(posedge clk) begin
    if (adv) begin
      lb1[pos_col] <= pix_in;
      lb2[pos_col] <= lb1_rd;
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb2_rd;
      win[1][2] <= lb1_rd;
      win[2][2] <= pix_in;
    end
  end

  // Sobel kernels as unsigned positive/negative halves, then absolute differences
  always_comb begin
    gx_pos = MAG_W'(win[2][0]) + (MAG_W'(win[2][1]) << 1) + MAG_W'(win[2][2]);
    gx_neg = MAG_W'(win[0][0]) + (MAG_W'(win[0][1]) << 1) + MAG_W'(win[0][2]);
    gy_pos = MAG_W'(win[0][2]) + (MAG_W'(win[1][2]) << 1) + MAG_W'(win[2][2]);
    gy_neg = MAG_W'(win[0][0]) + (MAG_W'(win[1][0]) << 1) + MAG_W'(win[2][0]);
    ax_c   = (gx_pos >= gx_neg) ? gx_pos - gx_neg : gx_neg - gx_pos;
    ay_c   = (gy_pos >= gy_neg) ? gy_pos - gy_neg : gy_neg - gy_pos;
  end

  // Magnitude, then power-of-two scaling by the previous frame's peak with saturation
  always_comb begin
    mag_hi = (s1_ax >= s1_ay) ? s1_ax : s1_ay;
    mag_lo = (s1_ax >= s1_ay) ? s1_ay : s1_ax;
    if (MAG_MODE == 1) mag_c = mag_hi + (mag_lo >> 1);
    else               mag_c = s1_ax + s1_ay;
    if (p_q >= P_UNITY) scaled = WW'(mag_c) >> (p_q - P_UNITY);
    else                scaled = WW'(mag_c) << (P_UNITY - p_q);
    norm_c = (|scaled[WW-1:DATA_W]) ? '1 : scaled[DATA_W-1:0];
  end

  // MSB index of the running peak, used as next frame's exponent
  always_comb begin
    p_next = P_UNITY;
    for (int i = 0; i < MAG_W; i++) begin
      if (run_max[i]) p_next = PW'(i);
    end
  end

  // Window tag, gradient and output stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_valid   <= 1'b0;
      w_sof     <= 1'b0;
      w_eol     <= 1'b0;
      w_border  <= 1'b0;
      s1_valid  <= 1'b0;
      s1_sof    <= 1'b0;
      s1_eol    <= 1'b0;
      s1_border <= 1'b0;
      s1_ax     <= '0;
      s1_ay     <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_data  <= '0;
    end else if (step) begin
      w_valid   <= adv && produce;
      w_sof     <= (c_row == '0) && (c_col == '0);
      w_eol     <= (c_col == COL_LAST);
      w_border  <= c_border;
      s1_valid  <= w_valid;
      s1_sof    <= w_sof;
      s1_eol    <= w_eol;
      s1_border <= w_border;
      s1_ax     <= ax_c;
      s1_ay     <= ay_c;
      out_valid <= s1_valid;
      out_sof   <= s1_valid && s1_sof;
      out_eol   <= s1_valid && s1_eol;
      out_data  <= s1_border ? '0 : norm_c;
    end
  end

  // State, raster position and per-frame peak tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      active_q  <= 1'b0;
      pos_col   <= '0;
      pos_row   <= '0;
      run_max   <= '0;
      frame_max <= '0;
      p_q       <= P_UNITY;
    end else begin
      active_q <= 1'b1;
      state_q  <= state_d;
      if (frame_done) begin
        pos_col <= '0;
        pos_row <= '0;
      end else if (adv) begin
        if (pos_col == COL_LAST) begin
          pos_col <= '0;
          pos_row <= (pos_row == ROW_FLEND) ? ROW_FL : pos_row + RW'(1);
        end else begin
          pos_col <= pos_col + CW'(1);
        end
      end
      if (frame_done) begin
        frame_max <= run_max;
        p_q       <= p_next;
        run_max   <= '0;
      end else if (step && s1_valid && !s1_border && mag_c > run_max) begin
        run_max <= mag_c;
      end
    end
  end
endmodule
